// File: rtl/retire_trace_emitter.sv
// retire_trace_emitter
//   Producer side of the CPU retire-trace interface. It samples the WB-stage
//   commit signals and classifies each retired instruction as NOP/branch,
//   REG, LOAD, STORE or HALT. Each instruction gets a 16-bit number, and the
//   record is queued in an internal FIFO. Sinks drain the FIFO through a
//   valid/ready stream.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     retire, pc, regwrite, dst_reg, dst_data, memread, memwrite,
//     mem_addr, mem_data, hlt
//                           commit-side taps
//     rec_valid/rec_ready   record stream handshake
//     rec_kind, rec_inum, rec_pc, rec_reg, rec_a, rec_b
//                           head-of-FIFO record (all zero when empty)
//     rec_cycle             push-cycle stamp (TRACE_CYCLE_STAMP_EN only)
//     stall_req             registered almost-full request to the pipeline
//     overflow              sticky: a record was dropped
//     done                  HALT record has been accepted by the sink
//
//   Optional feature macro: TRACE_CYCLE_STAMP_EN. It adds a 32-bit
//   saturating cycle counter and the per-entry rec_cycle output.
module retire_trace_emitter #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic [15:0] pc,
  input  logic        regwrite,
  input  logic [3:0]  dst_reg,
  input  logic [15:0] dst_data,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_kind,
  output logic [15:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [3:0]  rec_reg,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0] rec_cycle,
`endif
  output logic        stall_req,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_LVL = AW'(0) + (AW+1)'(DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic [2:0] {K_NOP, K_REG, K_LOAD, K_STORE, K_HALT} kind_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rreg;
    logic [15:0] a;
    logic [15:0] b;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
`endif
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        new_entry, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   inum_q, inum_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;
  state_e        state_q, state_d;
  logic          empty, full, qualify, push, pop;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]   cyc_q, cyc_d;
`endif

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_LVL);
    pop        = !empty && rec_ready;
    qualify    = retire && (state_q == S_RUN);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = qualify && (!full || pop);

    new_entry      = '0;
    new_entry.inum = inum_q;
    new_entry.pc   = pc;
`ifdef TRACE_CYCLE_STAMP_EN
    new_entry.cyc  = cyc_q;
`endif
    if (hlt) begin
      new_entry.kind = K_HALT;
    end else if (regwrite && memread) begin
      new_entry.kind = K_LOAD;
      new_entry.rreg = dst_reg;
      new_entry.a    = dst_data;
      new_entry.b    = mem_addr;
    end else if (regwrite) begin
      new_entry.kind = K_REG;
      new_entry.rreg = dst_reg;
      new_entry.a    = dst_data;
    end else if (memwrite) begin
      new_entry.kind = K_STORE;
      new_entry.a    = mem_addr;
      new_entry.b    = mem_data;
    end else begin
      new_entry.kind = K_NOP;
    end

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    stall_d    = (count_d >= AFULL_LVL);
    inum_d     = qualify ? inum_q + 1'b1 : inum_q;
    overflow_d = overflow_q || (qualify && !push);

`ifdef TRACE_CYCLE_STAMP_EN
    cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
`endif

    // A dropped HALT still moves to DRAIN; it never pops, so done stays low.
    state_d = state_q;
    case (state_q)
      S_RUN:   if (qualify && hlt) state_d = S_DRAIN;
      S_DRAIN: if (pop && head.kind == K_HALT) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inum_q     <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= S_RUN;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q      <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inum_q     <= inum_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q      <= cyc_d;
`endif
    end
  end

  // Storage needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_comb begin
    rec_valid = !empty;
    rec_kind  = empty ? '0 : head.kind;
    rec_inum  = empty ? '0 : head.inum;
    rec_pc    = empty ? '0 : head.pc;
    rec_reg   = empty ? '0 : head.rreg;
    rec_a     = empty ? '0 : head.a;
    rec_b     = empty ? '0 : head.b;
`ifdef TRACE_CYCLE_STAMP_EN
    rec_cycle = empty ? '0 : head.cyc;
`endif
    stall_req = stall_q;
    overflow  = overflow_q;
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_retire_trace_emitter.sv
// Directed self-checking bench for retire_trace_emitter (DEPTH=8, AFULL_MARGIN=2).
// Inputs are driven on the falling edge and outputs are sampled there too.
module tb_retire_trace_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire, regwrite, memread, memwrite, hlt, rec_ready;
  logic [15:0] pc, dst_data, mem_addr, mem_data;
  logic [3:0]  dst_reg;
  logic        rec_valid, stall_req, overflow, done;
  logic [2:0]  rec_kind;
  logic [15:0] rec_inum, rec_pc, rec_a, rec_b;
  logic [3:0]  rec_reg;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] rec_cycle;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  retire_trace_emitter #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc), .regwrite(regwrite),
    .dst_reg(dst_reg), .dst_data(dst_data), .memread(memread), .memwrite(memwrite),
    .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_a(rec_a),
    .rec_b(rec_b),
`ifdef TRACE_CYCLE_STAMP_EN
    .rec_cycle(rec_cycle),
`endif
    .stall_req(stall_req), .overflow(overflow), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [2:0] k, input logic [15:0] n,
                            input logic [15:0] p, input logic [3:0] r,
                            input logic [15:0] a, input logic [15:0] b);
    check({tag, ".valid"}, 32'(rec_valid), 32'd1);
    check({tag, ".kind"},  32'(rec_kind), 32'(k));
    check({tag, ".inum"},  32'(rec_inum), 32'(n));
    check({tag, ".pc"},    32'(rec_pc),   32'(p));
    check({tag, ".reg"},   32'(rec_reg),  32'(r));
    check({tag, ".a"},     32'(rec_a),    32'(a));
    check({tag, ".b"},     32'(rec_b),    32'(b));
  endtask

  task automatic drive_idle();
    retire = 0; regwrite = 0; memread = 0; memwrite = 0; hlt = 0;
    pc = '0; dst_reg = '0; dst_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  // k: 0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 HALT
  task automatic retire_op(input logic [2:0] k, input logic [15:0] p, input logic [3:0] r,
                           input logic [15:0] d, input logic [15:0] ad, input logic [15:0] md);
    retire = 1; pc = p; dst_reg = r; dst_data = d; mem_addr = ad; mem_data = md;
    regwrite = (k == 3'd1) || (k == 3'd2);
    memread  = (k == 3'd2);
    memwrite = (k == 3'd3);
    hlt      = (k == 3'd4);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_reset();
    rec_ready = 0;
    drive_idle();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    rec_ready = 0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("rst.valid", 32'(rec_valid), 0);
    check("rst.kind", 32'(rec_kind), 0);
    check("rst.inum", 32'(rec_inum), 0);
    check("rst.a", 32'(rec_a), 0);
    check("rst.stall", 32'(stall_req), 0);
    check("rst.ovf", 32'(overflow), 0);
    check("rst.done", 32'(done), 0);
    rst_n = 1;

    // Single REG record through an always-ready sink.
    rec_ready = 1;
    retire = 1; regwrite = 1; pc = 16'h0000; dst_reg = 4'd3; dst_data = 16'h00A5;
    #1 check("t1.no_fallthrough", 32'(rec_valid), 0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check_head("t1", 3'd1, 16'd0, 16'h0000, 4'd3, 16'h00A5, 16'h0000);
    @(negedge clk);
    check("t1.popped", 32'(rec_valid), 0);

    // LOAD, STORE, NOP field mapping.
    do_reset();
    retire_op(3'd2, 16'h0100, 4'd2, 16'h1234, 16'h0040, 16'h5555);
    retire_op(3'd3, 16'h0102, 4'd7, 16'h9999, 16'h0042, 16'hBEEF);
    retire_op(3'd0, 16'h0104, 4'd5, 16'h7777, 16'h1111, 16'h2222);
    rec_ready = 1;
    check_head("t2.load", 3'd2, 16'd0, 16'h0100, 4'd2, 16'h1234, 16'h0040);
    @(negedge clk);
    check_head("t2.store", 3'd3, 16'd1, 16'h0102, 4'd0, 16'h0042, 16'hBEEF);
    @(negedge clk);
    check_head("t2.nop", 3'd0, 16'd2, 16'h0104, 4'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t2.empty", 32'(rec_valid), 0);

    // Almost-full, overflow drop, in-order drain.
    do_reset();
    for (int i = 0; i < 5; i++) retire_op(3'd1, 16'(i), 4'd1, 16'(i), 16'h0, 16'h0);
    check("t3.stall_at5", 32'(stall_req), 0);
    retire_op(3'd1, 16'd5, 4'd1, 16'd5, 16'h0, 16'h0);
    check("t3.stall_at6", 32'(stall_req), 1);
    retire_op(3'd1, 16'd6, 4'd1, 16'd6, 16'h0, 16'h0);
    retire_op(3'd1, 16'd7, 4'd1, 16'd7, 16'h0, 16'h0);
    check("t3.ovf_at8", 32'(overflow), 0);
    retire_op(3'd1, 16'd8, 4'd1, 16'd8, 16'h0, 16'h0);
    check("t3.ovf_at9", 32'(overflow), 1);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3.drain%0d.valid", i), 32'(rec_valid), 1);
      check($sformatf("t3.drain%0d.inum", i), 32'(rec_inum), 32'(i));
      check($sformatf("t3.drain%0d.a", i), 32'(rec_a), 32'(i));
      @(negedge clk);
    end
    check("t3.drained", 32'(rec_valid), 0);
    check("t3.ovf_sticky", 32'(overflow), 1);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) retire_op(3'd1, 16'(i), 4'd1, 16'(i), 16'h0, 16'h0);
    rec_ready = 1;
    retire_op(3'd1, 16'd8, 4'd1, 16'd8, 16'h0, 16'h0);
    rec_ready = 0;
    check("t4.ovf", 32'(overflow), 0);
    check("t4.stall", 32'(stall_req), 1);
    rec_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4.drain%0d.valid", i), 32'(rec_valid), 1);
      check($sformatf("t4.drain%0d.inum", i), 32'(rec_inum), 32'(i));
      @(negedge clk);
    end
    check("t4.drained", 32'(rec_valid), 0);

    // HALT with two records ahead of it; a later retire is ignored.
    do_reset();
    retire_op(3'd1, 16'h0000, 4'd1, 16'h0011, 16'h0, 16'h0);
    retire_op(3'd1, 16'h0002, 4'd2, 16'h0022, 16'h0, 16'h0);
    retire_op(3'd4, 16'h0010, 4'd9, 16'h3333, 16'h4444, 16'h5555);
    retire_op(3'd1, 16'h0012, 4'd3, 16'h0033, 16'h0, 16'h0);
    check("t5.done_early", 32'(done), 0);
    rec_ready = 1;
    check("t5.r0.inum", 32'(rec_inum), 0);
    @(negedge clk);
    check("t5.r1.inum", 32'(rec_inum), 1);
    @(negedge clk);
    check_head("t5.halt", 3'd4, 16'd2, 16'h0010, 4'd0, 16'h0000, 16'h0000);
    check("t5.done_before_pop", 32'(done), 0);
    @(negedge clk);
    check("t5.done", 32'(done), 1);
    check("t5.ignored", 32'(rec_valid), 0);
    @(negedge clk);
    check("t5.done_hold", 32'(done), 1);
    #2 rst_n = 0;
    #1 check("t5.done_rst", 32'(done), 0);
    @(negedge clk);
    rst_n = 1;

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 9; i++) retire_op(3'd1, 16'(i), 4'd1, 16'(i), 16'h0, 16'h0);
    check("t6.ovf_pre", 32'(overflow), 1);
    check("t6.stall_pre", 32'(stall_req), 1);
    rec_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("t6.mid_inum", 32'(rec_inum), 2);
    #2 rst_n = 0;
    #1;
    check("t6.rst_valid", 32'(rec_valid), 0);
    check("t6.rst_stall", 32'(stall_req), 0);
    check("t6.rst_ovf", 32'(overflow), 0);
    check("t6.rst_done", 32'(done), 0);
    @(negedge clk);
    rec_ready = 0;
    rst_n = 1;
    repeat (3) @(negedge clk);
    retire_op(3'd1, 16'h0020, 4'd4, 16'h0044, 16'h0, 16'h0);
    check_head("t6.after", 3'd1, 16'd0, 16'h0020, 4'd4, 16'h0044, 16'h0000);
`ifdef TRACE_CYCLE_STAMP_EN
    check("t6.cycle", rec_cycle, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
